// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: round-robin write/read burst sequencer for the MIG DDR3 app_* interface.
// Optional per-direction beat counters are enabled with DDR3_ARB_STATS_EN.
module ddr3_rw_arbiter #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_STEP  = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    ui_clk,
   input  logic                    ui_clk_sync_rst,
   input  logic                    init_calib_complete,
   input  logic                    wr_req,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [LEN_WIDTH-1:0]    wr_len,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    wr_data_rd,
   output logic                    wr_done,
   input  logic                    rd_req,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [LEN_WIDTH-1:0]    rd_len,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_data_vld,
   output logic                    rd_done,
   output logic                    busy,
   output logic [ADDR_WIDTH-1:0]   app_addr,
   output logic [2:0]              app_cmd,
   output logic                    app_en,
   input  logic                    app_rdy,
   output logic [DATA_WIDTH-1:0]   app_wdf_data,
   output logic                    app_wdf_wren,
   output logic                    app_wdf_end,
   input  logic                    app_wdf_rdy,
   output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic [DATA_WIDTH-1:0]   app_rd_data,
   input  logic                    app_rd_data_valid
`ifdef DDR3_ARB_STATS_EN
   ,
   output logic [31:0]             wr_beat_cnt,
   output logic [31:0]             rd_beat_cnt
`endif
);
   localparam logic [1:0] IDLE = 2'd0, WR_BURST = 2'd1, RD_CMD = 2'd2, RD_WAIT = 2'd3;
   localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
   logic [1:0]            state;
   logic                  last_rd;
   logic [ADDR_WIDTH-1:0] base;
   logic [LEN_WIDTH-1:0]  len, issued, returned, ret_nxt, req_len;
   logic                  accept, grant_ok, pick_wr, pick_rd, last_cmd, ret_all, cmd_state;
   always_comb begin
      accept       = app_rdy & app_wdf_rdy;
      grant_ok     = init_calib_complete & ~wr_done & ~rd_done;
      // last_rd set means the read side was served last, so a write wins a tie
      pick_wr      = grant_ok & wr_req & (~rd_req | last_rd);
      pick_rd      = grant_ok & rd_req & ~pick_wr;
      req_len      = pick_wr ? wr_len : rd_len;
      cmd_state    = state == WR_BURST || state == RD_CMD;
      rd_data_vld  = app_rd_data_valid & (state == RD_CMD || state == RD_WAIT);
      ret_nxt      = returned + {{(LEN_WIDTH-1){1'b0}}, rd_data_vld};
      last_cmd     = issued == len - ONE;
      ret_all      = ret_nxt == len;
      app_wdf_wren = state == WR_BURST & accept;
      app_wdf_end  = app_wdf_wren;
      wr_data_rd   = app_wdf_wren;
      app_en       = state == WR_BURST ? accept : state == RD_CMD & app_rdy;
      app_cmd      = {2'b00, state == RD_CMD};
      app_addr     = cmd_state ? base + ADDR_WIDTH'(issued) * ADDR_WIDTH'(ADDR_STEP) : '0;
      app_wdf_data = wr_data;
      app_wdf_mask = '0;
      rd_data      = app_rd_data;
      busy         = state != IDLE;
   end
   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         state    <= IDLE;
         last_rd  <= 1'b1;
         base     <= '0;
         len      <= '0;
         issued   <= '0;
         returned <= '0;
         wr_done  <= 1'b0;
         rd_done  <= 1'b0;
      end else begin
         wr_done  <= 1'b0;
         rd_done  <= 1'b0;
         returned <= ret_nxt;
         case (state)
            IDLE: if (pick_wr | pick_rd) begin
               base     <= pick_wr ? wr_addr : rd_addr;
               len      <= req_len;
               issued   <= '0;
               returned <= '0;
               last_rd  <= pick_rd;
               if (req_len == '0) begin
                  wr_done <= pick_wr;
                  rd_done <= pick_rd;
               end else
                  state <= pick_wr ? WR_BURST : RD_CMD;
            end
            WR_BURST: if (accept) begin
               issued <= issued + ONE;
               if (last_cmd) begin
                  state   <= IDLE;
                  wr_done <= 1'b1;
               end
            end
            RD_CMD: if (app_rdy) begin
               issued <= issued + ONE;
               if (last_cmd) begin
                  state   <= ret_all ? IDLE : RD_WAIT;
                  rd_done <= ret_all;
               end
            end
            default: if (ret_all) begin
               state   <= IDLE;
               rd_done <= 1'b1;
            end
         endcase
      end
   end
`ifdef DDR3_ARB_STATS_EN
   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         wr_beat_cnt <= '0;
         rd_beat_cnt <= '0;
      end else begin
         wr_beat_cnt <= wr_beat_cnt + {31'b0, wr_data_rd};
         rd_beat_cnt <= rd_beat_cnt + {31'b0, rd_data_vld};
      end
   end
`endif
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb_ddr3_rw_arbiter: scoreboard bench for ddr3_rw_arbiter with a simple MIG read-return model.
module tb_ddr3_rw_arbiter;
   logic         ui_clk = 1'b0, ui_clk_sync_rst = 1'b1, init_calib_complete = 1'b0;
   logic         wr_req = 1'b0, rd_req = 1'b0;
   logic [27:0]  wr_addr = '0, rd_addr = '0;
   logic [7:0]   wr_len = '0, rd_len = '0;
   logic [127:0] wr_data, rd_data, app_wdf_data, app_rd_data, mdl_data = '0, inj_data = '0;
   logic         wr_data_rd, wr_done, rd_data_vld, rd_done, busy, app_en, app_wdf_wren, app_wdf_end;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic [15:0]  app_wdf_mask;
   logic         app_rdy, app_wdf_rdy = 1'b1, app_rd_data_valid;
   logic         rdy_tog = 1'b0, rdy_lvl = 1'b1, tog = 1'b0, mdl_vld = 1'b0, inj_vld = 1'b0, busy_mon = 1'b0;
`ifdef DDR3_ARB_STATS_EN
   logic [31:0]  wr_beat_cnt, rd_beat_cnt, wr_snap, rd_snap;
`endif
   int tests = 0, fails = 0, wseq = 0, wdat_idx = 0, cyc = 0, busy_lo = 0;
   typedef struct {logic [2:0] cmd; logic [27:0] addr; logic [127:0] data;} cmd_t;
   typedef struct {int t; logic [27:0] a;} pend_t;
   cmd_t   exp_cmd[$];
   logic [127:0] exp_rd[$];
   bit     exp_done[$];
   pend_t  pend[$];

   function automatic logic [127:0] wd(input int n);
      return {4{32'hA500_0000 | n}};
   endfunction
   function automatic logic [127:0] rdat(input logic [27:0] a);
      return {4{4'hC, a}};
   endfunction

   assign wr_data           = wd(wdat_idx);
   assign app_rdy           = rdy_tog ? tog : rdy_lvl;
   assign app_rd_data_valid = mdl_vld | inj_vld;
   assign app_rd_data       = inj_vld ? inj_data : mdl_data;

   ddr3_rw_arbiter dut (
      .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst), .init_calib_complete(init_calib_complete),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
      .wr_data_rd(wr_data_rd), .wr_done(wr_done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_data(rd_data),
      .rd_data_vld(rd_data_vld), .rd_done(rd_done), .busy(busy),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_rdy(app_wdf_rdy), .app_wdf_mask(app_wdf_mask),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
`ifdef DDR3_ARB_STATS_EN
      , .wr_beat_cnt(wr_beat_cnt), .rd_beat_cnt(rd_beat_cnt)
`endif
   );

   always #5 ui_clk = ~ui_clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // MIG stand-ins: toggling ready, write FIFO pop, read data returned 20 cycles after the command
   always @(posedge ui_clk) begin
      tog     <= ~tog;
      cyc     <= cyc + 1;
      mdl_vld <= 1'b0;
      if (!ui_clk_sync_rst && wr_data_rd) wdat_idx <= wdat_idx + 1;
      if (!ui_clk_sync_rst && app_en && app_cmd == 3'd1 && app_rdy) pend.push_back('{cyc + 20, app_addr});
      if (pend.size() != 0 && pend[0].t == cyc) begin
         mdl_vld  <= 1'b1;
         mdl_data <= rdat(pend[0].a);
         void'(pend.pop_front());
      end
   end

   always @(negedge ui_clk) if (!ui_clk_sync_rst) begin
      cmd_t e;
      if (busy_mon && !busy) busy_lo <= busy_lo + 1;
      if (app_wdf_wren | app_wdf_end | wr_data_rd) chk("strobe_without_app_en", app_en, 1);
      if (app_en) begin
         chk("app_en_only_when_rdy", app_rdy, 1);
         chk("cmd_expected", exp_cmd.size() != 0, 1);
         if (exp_cmd.size() != 0) begin
            e = exp_cmd.pop_front();
            chk("app_cmd", app_cmd, e.cmd);
            chk("app_addr", app_addr, e.addr);
            if (e.cmd == 3'd0) begin
               chk("app_wdf_data", app_wdf_data, e.data);
               chk("wdf_strobes", {app_wdf_wren, app_wdf_end, wr_data_rd}, 3'b111);
            end
         end
      end
      if (rd_data_vld) begin
         chk("rd_beat_expected", exp_rd.size() != 0, 1);
         if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd.pop_front());
      end
      if (wr_done) begin
         chk("wr_done_expected", exp_done.size() != 0, 1);
         if (exp_done.size() != 0) chk("done_order_wr", exp_done.pop_front(), 0);
      end
      if (rd_done) begin
         chk("rd_done_expected", exp_done.size() != 0, 1);
         if (exp_done.size() != 0) chk("done_order_rd", exp_done.pop_front(), 1);
      end
   end

   task automatic tick();
      @(posedge ui_clk);
      #1;
   endtask

   task automatic push_w(input logic [27:0] a);
      exp_cmd.push_back('{3'd0, a, wd(wseq)});
      wseq++;
   endtask

   task automatic push_r(input logic [27:0] a);
      exp_cmd.push_back('{3'd1, a, 128'd0});
      exp_rd.push_back(rdat(a));
   endtask

   task automatic wait_pulse(input bit rd, input int exp_n, input string name);
      int n = -1;
      for (int i = 1; i <= 300 && n < 0; i++) begin
         tick();
         if (rd ? rd_done : wr_done) n = i;
      end
      if (exp_n > 0) chk(name, n, exp_n);
      else chk(name, n > 0, 1);
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_outputs", {busy, app_en, app_wdf_wren, app_wdf_end, wr_data_rd, wr_done, rd_done,
                            rd_data_vld, app_cmd, app_addr}, 0);
      chk("wdf_mask", app_wdf_mask, 0);
      ui_clk_sync_rst = 1'b0;
      wr_req = 1'b1; wr_addr = 28'h100; wr_len = 8'd4;
      repeat (5) tick();
      chk("calib_gate_busy", busy, 0);

      // write only
      for (int i = 0; i < 4; i++) push_w(28'h100 + 28'(i * 8));
      exp_done.push_back(1'b0);
`ifdef DDR3_ARB_STATS_EN
      wr_snap = wr_beat_cnt;
`endif
      init_calib_complete = 1'b1;
      wait_pulse(0, 5, "wr_done_latency");
      chk("done_cycle_idle", busy, 0);
      wr_req = 1'b0;
      tick();
      chk("wr_done_one_cycle", wr_done, 0);
`ifdef DDR3_ARB_STATS_EN
      chk("wr_beat_cnt_delta", wr_beat_cnt - wr_snap, 4);
      rd_snap = rd_beat_cnt;
`endif

      // read with ready backpressure
      rdy_tog = 1'b1;
      rd_addr = 28'h2000; rd_len = 8'd3;
      for (int i = 0; i < 3; i++) push_r(28'h2000 + 28'(i * 8));
      exp_done.push_back(1'b1);
      rd_req = 1'b1;
      tick();
      busy_mon = 1'b1;
      wait_pulse(1, 0, "rd_done_seen");
      busy_mon = 1'b0;
      rd_req = 1'b0; rdy_tog = 1'b0; rdy_lvl = 1'b1;
      tick();
      chk("busy_through_read", busy_lo, 0);
`ifdef DDR3_ARB_STATS_EN
      chk("rd_beat_cnt_delta", rd_beat_cnt - rd_snap, 3);
`endif

      // contention from reset: write first, then read, then re-asserted write beats held read
      ui_clk_sync_rst = 1'b1;
      tick();
      ui_clk_sync_rst = 1'b0;
      push_w(28'h300); push_w(28'h308); push_r(28'h400); push_r(28'h408);
      push_w(28'h500); push_r(28'h400); push_r(28'h408);
      exp_done.push_back(1'b0); exp_done.push_back(1'b1);
      exp_done.push_back(1'b0); exp_done.push_back(1'b1);
      wr_addr = 28'h300; wr_len = 8'd2; rd_addr = 28'h400; rd_len = 8'd2;
      wr_req = 1'b1; rd_req = 1'b1;
      wait_pulse(0, 3, "contention_wr_first");
      wr_req = 1'b0;
      repeat (3) tick();
      wr_addr = 28'h500; wr_len = 8'd1; wr_req = 1'b1;
      wait_pulse(1, 0, "contention_rd_done");
      wait_pulse(0, 0, "regrant_wr_done");
      wr_req = 1'b0;
      wait_pulse(1, 0, "held_rd_done");
      rd_req = 1'b0;
      tick();

      // address wrap and zero-length requests
      push_w(28'hFFFFFF8); push_w(28'h0000000);
      exp_done.push_back(1'b0);
      wr_addr = 28'hFFFFFF8; wr_len = 8'd2; wr_req = 1'b1;
      wait_pulse(0, 3, "wrap_wr_done");
      wr_req = 1'b0;
      tick();
      exp_done.push_back(1'b0);
      wr_len = 8'd0; wr_req = 1'b1;
      wait_pulse(0, 1, "zero_len_wr_done");
      chk("zero_len_not_busy", busy, 0);
      wr_req = 1'b0;
      tick();
      exp_done.push_back(1'b1);
      rd_len = 8'd0; rd_req = 1'b1;
      wait_pulse(1, 1, "zero_len_rd_done");
      rd_req = 1'b0;
      tick();

      // reset in the middle of a 5-beat write, then a stray read-valid in IDLE
      push_w(28'h600); push_w(28'h608);
      wr_addr = 28'h600; wr_len = 8'd5; wr_req = 1'b1;
      repeat (3) tick();
      chk("mid_burst_busy", busy, 1);
      ui_clk_sync_rst = 1'b1; wr_req = 1'b0;
      tick();
      chk("reset_mid_burst_outputs", {busy, app_en, app_wdf_wren, app_wdf_end, wr_data_rd, wr_done,
                                      rd_done, rd_data_vld, app_cmd, app_addr}, 0);
      ui_clk_sync_rst = 1'b0;
      inj_data = {4{32'hDEAD_BEEF}}; inj_vld = 1'b1;
      tick();
      chk("stale_rd_dropped", rd_data_vld, 0);
      chk("idle_after_reset", busy, 0);
      inj_vld = 1'b0;
      repeat (2) tick();

      chk("cmd_queue_drained", exp_cmd.size(), 0);
      chk("rd_queue_drained", exp_rd.size(), 0);
      chk("done_queue_drained", exp_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
